// File: rtl/hexdisp_scan.sv
// hexdisp_scan: time-multiplexed 8-digit hex display driver with frame-aligned capture
module hexdisp_scan #(
    parameter int CLK_DIV = 50000,
    parameter int GUARD   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] value_in,
    input  logic [7:0]  dp_in,
    input  logic        blank_lz,
    input  logic        enable,
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_done
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [31:0]   r_shadow_val;
    logic [7:0]    r_shadow_dp;
    logic [7:0]    r_an_n;
    logic [6:0]    r_seg_n;
    logic          r_dp_n;
    logic          r_frame_done;

    logic          w_last;
    logic          w_frame;
    logic [31:0]   w_hi;
    logic [3:0]    w_nib;
    logic          w_blank;
    logic          w_drive;
    logic [6:0]    w_seg;

    assign w_last  = r_cnt == CW'(CLK_DIV - 1);
    assign w_frame = w_last && r_idx == 3'd7;
    // Shifting the shadow down to the current digit leaves exactly nibbles idx..7,
    // so a zero result means this digit and everything left of it are zero.
    assign w_hi    = r_shadow_val >> {r_idx, 2'b00};
    assign w_nib   = w_hi[3:0];
    assign w_blank = blank_lz && r_idx != 3'd0 && w_hi == 32'd0;
    assign w_drive = int'(r_cnt) >= GUARD && enable && !w_blank;

    // Hex nibble to active-low {g,f,e,d,c,b,a} segment pattern
    always_comb begin
        w_seg = 7'h7F;
        case (w_nib)
            4'h0: w_seg = 7'h40;
            4'h1: w_seg = 7'h79;
            4'h2: w_seg = 7'h24;
            4'h3: w_seg = 7'h30;
            4'h4: w_seg = 7'h19;
            4'h5: w_seg = 7'h12;
            4'h6: w_seg = 7'h02;
            4'h7: w_seg = 7'h78;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h10;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h03;
            4'hC: w_seg = 7'h46;
            4'hD: w_seg = 7'h21;
            4'hE: w_seg = 7'h06;
            default: w_seg = 7'h0E;
        endcase
    end

    // Slot prescaler and digit index; the index advances on the last cycle of each slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
        end else begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            r_idx <= w_last ? r_idx + 3'd1 : r_idx;
        end
    end

    // Capture the displayed word only at the frame boundary so a frame never tears
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow_val <= 32'd0;
            r_shadow_dp  <= 8'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_shadow_val <= w_frame ? value_in : r_shadow_val;
            r_shadow_dp  <= w_frame ? dp_in : r_shadow_dp;
            r_frame_done <= w_frame;
        end
    end

    // Registered pin drivers; everything dark during guard, disable or blanking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_an_n  <= 8'hFF;
            r_seg_n <= 7'h7F;
            r_dp_n  <= 1'b1;
        end else begin
            r_an_n  <= w_drive ? ~(8'd1 << r_idx) : 8'hFF;
            r_seg_n <= w_drive ? w_seg : 7'h7F;
            r_dp_n  <= w_drive ? ~r_shadow_dp[r_idx] : 1'b1;
        end
    end

    assign an_n       = r_an_n;
    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_hexdisp_scan.sv
// tb_hexdisp_scan: randomized and directed checks of hexdisp_scan against a time-based reference model
module tb_hexdisp_scan;
    localparam int D = 4;
    localparam int G = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] value_in = 32'd0;
    logic [7:0]  dp_in = 8'd0;
    logic        blank_lz = 1'b0;
    logic        enable = 1'b1;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_done;

    int total = 0;
    int bad = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int          t = 0;
    logic [31:0] m_val = 32'd0;
    logic [7:0]  m_dp = 8'd0;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;
    int          fd_seen = 0;

    hexdisp_scan #(.CLK_DIV(D), .GUARD(G)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .value_in(value_in),
        .dp_in(dp_in),
        .blank_lz(blank_lz),
        .enable(enable),
        .an_n(an_n),
        .seg_n(seg_n),
        .dp_n(dp_n),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, t);
        end
    endtask

    // Reference: time since reset determines the slot and digit; pins show the previous cycle's view
    task automatic model();
        int c, k;
        logic lz, drv;
        logic [3:0] nib;
        if (!rst_n) begin
            t = 0; m_val = 32'd0; m_dp = 8'd0;
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
        end else begin
            c = t % D;
            k = (t / D) % 8;
            nib = 4'((m_val >> (4 * k)) & 32'hF);
            lz = 1'b1;
            for (int j = k; j < 8; j++)
                if (((m_val >> (4 * j)) & 32'hF) != 0) lz = 1'b0;
            drv = (c >= G) && enable && !(blank_lz && k != 0 && lz);
            e_an  = drv ? ~(8'd1 << k) : 8'hFF;
            e_seg = drv ? seg_tab[nib] : 7'h7F;
            e_dp  = drv ? ~m_dp[k] : 1'b1;
            e_fd  = (c == D - 1) && (k == 7);
            if (e_fd) begin
                m_val = value_in;
                m_dp = dp_in;
            end
            t++;
        end
    endtask

    task automatic step(input logic r, input logic [31:0] v, input logic [7:0] d,
                        input logic b, input logic e);
        rst_n = r; value_in = v; dp_in = d; blank_lz = b; enable = e;
        @(posedge clk);
        model();
        @(negedge clk);
        check("an_n", 32'(an_n), 32'(e_an));
        check("seg_n", 32'(seg_n), 32'(e_seg));
        check("dp_n", 32'(dp_n), 32'(e_dp));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("an_onehot", 32'($countones(~an_n) <= 1), 32'd1);
        if (frame_done === 1'b1) fd_seen++;
    endtask

    initial begin
        logic [31:0] v;
        logic [7:0] d;
        logic b, e;
        // Reset with arbitrary inputs, then an all-zero first frame
        for (int i = 0; i < 3; i++) step(1'b0, $urandom, 8'($urandom), 1'b1, 1'b1);
        for (int i = 0; i < 32; i++) step(1'b1, 32'h1234ABCD, 8'h01, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) step(1'b1, 32'h1234ABCD, 8'h01, 1'b0, 1'b1);
        // Tear-free capture: 1111_1111 captured, FFFF_FFFF written during slot 3
        for (int i = 0; i < 32; i++) step(1'b1, 32'h1111_1111, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 14; i++) step(1'b1, 32'h1111_1111, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 50; i++) step(1'b1, 32'hFFFF_FFFF, 8'hFF, 1'b0, 1'b1);
        // Leading-zero suppression
        for (int i = 0; i < 64; i++) step(1'b1, 32'h0000_00A0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 64; i++) step(1'b1, 32'h0, 8'h00, 1'b1, 1'b1);
        // Disabled for 64 cycles: frame_done still pulses exactly twice
        fd_seen = 0;
        for (int i = 0; i < 64; i++) step(1'b1, 32'h8765_4321, 8'hAA, 1'b0, 1'b0);
        check("fd_count_disabled", fd_seen, 2);
        // Short reset during slot 5, then first pulse one frame later
        for (int i = 0; i < 20; i++) step(1'b1, 32'hCAFE_F00D, 8'h0F, 1'b0, 1'b1);
        step(1'b0, 32'hCAFE_F00D, 8'h0F, 1'b0, 1'b1);
        fd_seen = 0;
        for (int i = 0; i < 31; i++) step(1'b1, 32'hCAFE_F00D, 8'h0F, 1'b0, 1'b1);
        check("fd_none_early", fd_seen, 0);
        for (int i = 0; i < 40; i++) step(1'b1, 32'hCAFE_F00D, 8'h0F, 1'b0, 1'b1);
        // Randomized run
        v = $urandom; d = 8'($urandom); b = 1'b0; e = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 2))
                    0: v = $urandom;
                    1: v = $urandom >> (4 * $urandom_range(0, 7));
                    default: v = 32'd0;
                endcase
                d = 8'($urandom);
            end
            if ($urandom_range(0, 49) == 0) b = ~b;
            if ($urandom_range(0, 29) == 0) e = ~e;
            step(($urandom_range(0, 399) != 0), v, d, b, e);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
